dual_issue_scheduler: RTL and testbench

- Sits between fetch and the dual-lane decode/control stage. Accepts a fetched instruction pair (A = older, B = younger) and decides per cycle what lanes A and B receive.
- Splits a pair over two cycles on intra-pair hazards or when B is not lane-B-legal.
- Inserts load-use bubbles and drives the stall trigger into the control unit.
- Lane A executes all instruction classes; lane B executes ALU R/I-type and LUI only.

---
 rtl/issue_pkg.sv | 60 ++++++
 rtl/issue_hazard_check.sv | 44 ++++
 rtl/dual_issue_scheduler.sv | 203 ++++++++++++++++++++
 tb/tb_dual_issue_scheduler.sv | 146 ++++++++++++++
 4 files changed

// File: rtl/issue_pkg.sv
// Shared opcode constants, scheduler states and instruction-class helpers
// for the dual-issue scheduler.
package issue_pkg;

  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  typedef enum logic [1:0] {
    S_PAIR    = 2'd0,
    S_SPLIT_B = 2'd1,
    S_BUBBLE  = 2'd2
  } state_e;

  function automatic logic reads_rs1(input logic [6:0] op);
    case (op)
      OP_OP, OP_IMM, OP_LOAD, OP_STORE, OP_BRANCH, OP_JALR: reads_rs1 = 1'b1;
      default: reads_rs1 = 1'b0;
    endcase
  endfunction

  function automatic logic reads_rs2(input logic [6:0] op);
    case (op)
      OP_OP, OP_STORE, OP_BRANCH: reads_rs2 = 1'b1;
      default: reads_rs2 = 1'b0;
    endcase
  endfunction

  function automatic logic writes_rd(input logic [6:0] op);
    case (op)
      OP_OP, OP_IMM, OP_LOAD, OP_LUI, OP_AUIPC, OP_JAL, OP_JALR: writes_rd = 1'b1;
      default: writes_rd = 1'b0;
    endcase
  endfunction

  function automatic logic is_lane_b_legal(input logic [6:0] op);
    case (op)
      OP_OP, OP_IMM, OP_LUI: is_lane_b_legal = 1'b1;
      default: is_lane_b_legal = 1'b0;
    endcase
  endfunction

  function automatic logic is_load(input logic [6:0] op);
    is_load = (op == OP_LOAD);
  endfunction

  function automatic logic is_ctrl(input logic [6:0] op);
    case (op)
      OP_BRANCH, OP_JAL, OP_JALR: is_ctrl = 1'b1;
      default: is_ctrl = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/issue_hazard_check.sv
// Combinational intra-pair split and load-use detection; with pair_mode low
// only the first instruction is considered for issue.
module issue_hazard_check
  import issue_pkg::*;
(
  input  logic [31:0] ins_a,
  input  logic [31:0] ins_b,
  input  logic        pair_mode,
  input  logic        trk_valid,
  input  logic [4:0]  trk_rd,
  output logic        split,
  output logic        load_use
);

  logic [4:0] rd_a_s;
  logic       a_wr_s;
  logic       raw_s;
  logic       waw_s;
  logic       lu_a_s;
  logic       lu_b_s;
  logic       unused_s;

  assign unused_s = ^{ins_a[31:25], ins_a[14:12], ins_b[31:25], ins_b[14:12]};

  assign rd_a_s = ins_a[11:7];
  assign a_wr_s = writes_rd(ins_a[6:0]) && (rd_a_s != 5'd0);
  assign raw_s  = a_wr_s && ((reads_rs1(ins_b[6:0]) && (ins_b[19:15] == rd_a_s)) ||
                             (reads_rs2(ins_b[6:0]) && (ins_b[24:20] == rd_a_s)));
  assign waw_s  = a_wr_s && writes_rd(ins_b[6:0]) && (ins_b[11:7] == rd_a_s);

  assign split = pair_mode && (!is_lane_b_legal(ins_b[6:0]) || is_ctrl(ins_a[6:0]) ||
                               raw_s || waw_s);

  assign lu_a_s = trk_valid && (trk_rd != 5'd0) &&
                  ((reads_rs1(ins_a[6:0]) && (ins_a[19:15] == trk_rd)) ||
                   (reads_rs2(ins_a[6:0]) && (ins_a[24:20] == trk_rd)));
  assign lu_b_s = trk_valid && (trk_rd != 5'd0) &&
                  ((reads_rs1(ins_b[6:0]) && (ins_b[19:15] == trk_rd)) ||
                   (reads_rs2(ins_b[6:0]) && (ins_b[24:20] == trk_rd)));

  // A split pair only issues its older half now, so B is checked later
  assign load_use = lu_a_s || (pair_mode && !split && lu_b_s);

endmodule

// File: rtl/dual_issue_scheduler.sv
// Dual-lane issue scheduler: pair splitting and load-use bubbles.
// Optional performance counters under `ISSUE_PERF_CNT_EN.
module dual_issue_scheduler
  import issue_pkg::*;
#(
  parameter int XLEN             = 32,
  parameter int LOAD_USE_BUBBLES = 1
`ifdef ISSUE_PERF_CNT_EN
  , parameter int PERF_CNT_W     = 32
`endif
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            pair_valid,
  input  logic [XLEN-1:0] instr_a,
  input  logic [XLEN-1:0] instr_b,
  output logic            pair_ready,
  input  logic            exec_ready,
  input  logic            flush,
  output logic            issue_valid_a,
  output logic [XLEN-1:0] issue_instr_a,
  output logic            issue_valid_b,
  output logic [XLEN-1:0] issue_instr_b,
  output logic            trigger
`ifdef ISSUE_PERF_CNT_EN
  , output logic [PERF_CNT_W-1:0] perf_pairs
  , output logic [PERF_CNT_W-1:0] perf_splits
  , output logic [PERF_CNT_W-1:0] perf_bubbles
`endif
);

  state_e          state_r, ret_r, eff_state_s, nxt_state_s, nxt_ret_s;
  logic [1:0]      cnt_r, nxt_cnt_s;
  logic            trk_v_r, nxt_trk_v_s, trk_eff_v_s;
  logic [4:0]      trk_rd_r, nxt_trk_rd_s;
  logic [XLEN-1:0] held_r, nxt_held_s;
  logic            advance_s, in_bubble_s, bubble_done_s, ready_s;
  logic            split_s, load_use_s;
  logic [31:0]     chk_a_s;
  logic            nxt_va_s, nxt_vb_s, nxt_trig_s;
  logic [XLEN-1:0] nxt_ia_s, nxt_ib_s, issue_word_s;
  logic            issue_a_s, ev_pair_s, ev_split_s, ev_bubble_s;

  assign advance_s     = exec_ready | ~(issue_valid_a | issue_valid_b);
  assign in_bubble_s   = (state_r == S_BUBBLE);
  assign bubble_done_s = in_bubble_s && (cnt_r == 2'd0);
  assign trk_eff_v_s   = trk_v_r && !in_bubble_s;
  assign pair_ready    = advance_s & ~flush & ready_s;

  // State that decides this cycle's issue; the last bubble cycle acts as its return state
  always_comb begin
    if (bubble_done_s) begin
      eff_state_s = ret_r;
    end else begin
      eff_state_s = state_r;
    end
    if (eff_state_s == S_SPLIT_B) begin
      chk_a_s = held_r[31:0];
    end else begin
      chk_a_s = instr_a[31:0];
    end
  end

  issue_hazard_check u_hazard (
    .ins_a     (chk_a_s),
    .ins_b     (instr_b[31:0]),
    .pair_mode (eff_state_s == S_PAIR),
    .trk_valid (trk_eff_v_s),
    .trk_rd    (trk_rd_r),
    .split     (split_s),
    .load_use  (load_use_s)
  );

  // Next-state and issue-slot decision
  always_comb begin
    nxt_state_s  = state_r;
    nxt_ret_s    = ret_r;
    nxt_cnt_s    = cnt_r;
    nxt_va_s     = 1'b0;
    nxt_vb_s     = 1'b0;
    nxt_ia_s     = issue_instr_a;
    nxt_ib_s     = issue_instr_b;
    nxt_trig_s   = 1'b0;
    nxt_trk_v_s  = trk_v_r;
    nxt_trk_rd_s = trk_rd_r;
    nxt_held_s   = held_r;
    ready_s      = 1'b0;
    issue_a_s    = 1'b0;
    issue_word_s = instr_a;
    ev_pair_s    = 1'b0;
    ev_split_s   = 1'b0;
    ev_bubble_s  = 1'b0;
    if (in_bubble_s && (cnt_r != 2'd0)) begin
      nxt_cnt_s   = cnt_r - 2'd1;
      nxt_trig_s  = 1'b1;
      ev_bubble_s = 1'b1;
    end else if (load_use_s && ((eff_state_s == S_SPLIT_B) || pair_valid)) begin
      nxt_state_s = S_BUBBLE;
      nxt_ret_s   = eff_state_s;
      nxt_cnt_s   = 2'(LOAD_USE_BUBBLES - 1);
      nxt_trig_s  = 1'b1;
      ev_bubble_s = 1'b1;
    end else begin
      case (eff_state_s)
        S_SPLIT_B: begin
          nxt_va_s     = 1'b1;
          nxt_ia_s     = held_r;
          issue_a_s    = 1'b1;
          issue_word_s = held_r;
          ready_s      = 1'b1;
          nxt_state_s  = S_PAIR;
        end
        S_PAIR: begin
          nxt_state_s = S_PAIR;
          if (!pair_valid) begin
            nxt_va_s = 1'b0;
          end else if (split_s) begin
            nxt_va_s    = 1'b1;
            nxt_ia_s    = instr_a;
            issue_a_s   = 1'b1;
            nxt_held_s  = instr_b;
            nxt_state_s = S_SPLIT_B;
            ev_split_s  = 1'b1;
          end else begin
            nxt_va_s  = 1'b1;
            nxt_ia_s  = instr_a;
            nxt_vb_s  = 1'b1;
            nxt_ib_s  = instr_b;
            issue_a_s = 1'b1;
            ready_s   = 1'b1;
            ev_pair_s = 1'b1;
          end
        end
        default: begin
          nxt_state_s = S_PAIR;
        end
      endcase
    end
    if (issue_a_s) begin
      nxt_trk_v_s  = is_load(issue_word_s[6:0]) && (issue_word_s[11:7] != 5'd0);
      nxt_trk_rd_s = issue_word_s[11:7];
    end else if (bubble_done_s) begin
      nxt_trk_v_s = 1'b0;
    end else begin
      nxt_trk_v_s = trk_v_r;
    end
  end

  // Registered state and issue slots; flush clears, stalls hold everything
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r       <= S_PAIR;
      ret_r         <= S_PAIR;
      cnt_r         <= 2'd0;
      trk_v_r       <= 1'b0;
      trk_rd_r      <= 5'd0;
      held_r        <= '0;
      issue_valid_a <= 1'b0;
      issue_valid_b <= 1'b0;
      issue_instr_a <= '0;
      issue_instr_b <= '0;
      trigger       <= 1'b0;
    end else if (flush) begin
      state_r       <= S_PAIR;
      cnt_r         <= 2'd0;
      trk_v_r       <= 1'b0;
      issue_valid_a <= 1'b0;
      issue_valid_b <= 1'b0;
      trigger       <= 1'b0;
    end else if (advance_s) begin
      state_r       <= nxt_state_s;
      ret_r         <= nxt_ret_s;
      cnt_r         <= nxt_cnt_s;
      trk_v_r       <= nxt_trk_v_s;
      trk_rd_r      <= nxt_trk_rd_s;
      held_r        <= nxt_held_s;
      issue_valid_a <= nxt_va_s;
      issue_valid_b <= nxt_vb_s;
      issue_instr_a <= nxt_ia_s;
      issue_instr_b <= nxt_ib_s;
      trigger       <= nxt_trig_s;
    end
  end

`ifdef ISSUE_PERF_CNT_EN
  // Wrapping event counters, frozen while the issue stage stalls
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_pairs   <= '0;
      perf_splits  <= '0;
      perf_bubbles <= '0;
    end else if (!flush && advance_s) begin
      perf_pairs   <= perf_pairs + PERF_CNT_W'(ev_pair_s);
      perf_splits  <= perf_splits + PERF_CNT_W'(ev_split_s);
      perf_bubbles <= perf_bubbles + PERF_CNT_W'(ev_bubble_s);
    end
  end
`else
  logic unused_ev_s;
  assign unused_ev_s = ev_pair_s ^ ev_split_s ^ ev_bubble_s;
`endif

endmodule

// File: tb/tb_dual_issue_scheduler.sv
// Scoreboard bench for dual_issue_scheduler with two load-use bubble cycles.
module tb_dual_issue_scheduler;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        pair_valid = 1'b0;
  logic [31:0] instr_a = 32'd0;
  logic [31:0] instr_b = 32'd0;
  logic        pair_ready;
  logic        exec_ready = 1'b1;
  logic        flush = 1'b0;
  logic        issue_valid_a;
  logic [31:0] issue_instr_a;
  logic        issue_valid_b;
  logic [31:0] issue_instr_b;
  logic        trigger;

  typedef struct packed {
    logic        va;
    logic [31:0] ia;
    logic        vb;
    logic [31:0] ib;
    logic        trig;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  dual_issue_scheduler #(.XLEN(32), .LOAD_USE_BUBBLES(2)) dut (
    .clk(clk), .rst_n(rst_n), .pair_valid(pair_valid), .instr_a(instr_a),
    .instr_b(instr_b), .pair_ready(pair_ready), .exec_ready(exec_ready),
    .flush(flush), .issue_valid_a(issue_valid_a), .issue_instr_a(issue_instr_a),
    .issue_valid_b(issue_valid_b), .issue_instr_b(issue_instr_b), .trigger(trigger)
  );

  function automatic logic [31:0] r_add(input logic [4:0] rd, rs1, rs2);
    return {7'b0000000, rs2, rs1, 3'b000, rd, 7'b0110011};
  endfunction
  function automatic logic [31:0] i_addi(input logic [4:0] rd, rs1, input logic [11:0] imm);
    return {imm, rs1, 3'b000, rd, 7'b0010011};
  endfunction
  function automatic logic [31:0] i_lw(input logic [4:0] rd, rs1);
    return {12'd0, rs1, 3'b010, rd, 7'b0000011};
  endfunction
  function automatic logic [31:0] b_beq(input logic [4:0] rs1, rs2);
    return {7'b0000000, rs2, rs1, 3'b000, 5'b00000, 7'b1100011};
  endfunction

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic exp_t mk(input logic va, input logic [31:0] ia, input logic vb,
                              input logic [31:0] ib, input logic trig);
    exp_t e;
    e.va = va; e.ia = ia; e.vb = vb; e.ib = ib; e.trig = trig;
    return e;
  endfunction

  // Drive one cycle, check pair_ready, then compare the registered result
  task automatic step(input logic pv, input logic [31:0] a, input logic [31:0] b,
                      input logic er, input logic fl, input logic exp_rdy, input exp_t e);
    exp_t x;
    @(negedge clk);
    pair_valid = pv; instr_a = a; instr_b = b; exec_ready = er; flush = fl;
    #1;
    check_eq("pair_ready", {63'd0, pair_ready}, {63'd0, exp_rdy});
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    x = sb_q.pop_front();
    check_eq("valid_a", {63'd0, issue_valid_a}, {63'd0, x.va});
    check_eq("valid_b", {63'd0, issue_valid_b}, {63'd0, x.vb});
    check_eq("trigger", {63'd0, trigger}, {63'd0, x.trig});
    if (x.va) check_eq("instr_a", {32'd0, issue_instr_a}, {32'd0, x.ia});
    if (x.vb) check_eq("instr_b", {32'd0, issue_instr_b}, {32'd0, x.ib});
  endtask

  logic [31:0] p1a, p1b, rwa, rwb, lda, ldb, usa, usb, bqa, bqb, ina, inb;
  logic [31:0] wwa, wwb, lla, llb, sta, stb;

  initial begin
    p1a = r_add(5'd1, 5'd2, 5'd3);   p1b = i_addi(5'd4, 5'd5, 12'd1);
    rwa = i_addi(5'd1, 5'd0, 12'd5); rwb = r_add(5'd2, 5'd1, 5'd1);
    lda = i_lw(5'd5, 5'd2);          ldb = i_addi(5'd6, 5'd0, 12'd1);
    usa = r_add(5'd7, 5'd5, 5'd1);   usb = i_addi(5'd8, 5'd0, 12'd2);
    bqa = b_beq(5'd1, 5'd2);         bqb = r_add(5'd3, 5'd4, 5'd5);
    ina = r_add(5'd9, 5'd1, 5'd2);   inb = i_addi(5'd10, 5'd0, 12'd3);
    wwa = i_addi(5'd1, 5'd0, 12'd1); wwb = i_addi(5'd1, 5'd0, 12'd2);
    lla = r_add(5'd13, 5'd1, 5'd2);  llb = i_lw(5'd14, 5'd3);
    sta = r_add(5'd11, 5'd1, 5'd2);  stb = i_addi(5'd12, 5'd0, 12'd4);

    #3;
    check_eq("rst_valid_a", {63'd0, issue_valid_a}, 64'd0);
    check_eq("rst_valid_b", {63'd0, issue_valid_b}, 64'd0);
    check_eq("rst_trigger", {63'd0, trigger}, 64'd0);
    check_eq("rst_instr_a", {32'd0, issue_instr_a}, 64'd0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;

    step(1'b1, p1a, p1b, 1'b1, 1'b0, 1'b1, mk(1'b1, p1a, 1'b1, p1b, 1'b0));
    step(1'b1, rwa, rwb, 1'b1, 1'b0, 1'b0, mk(1'b1, rwa, 1'b0, 32'd0, 1'b0));
    step(1'b1, rwa, rwb, 1'b1, 1'b0, 1'b1, mk(1'b1, rwb, 1'b0, 32'd0, 1'b0));
    step(1'b1, lda, ldb, 1'b1, 1'b0, 1'b1, mk(1'b1, lda, 1'b1, ldb, 1'b0));
    step(1'b1, usa, usb, 1'b1, 1'b0, 1'b0, mk(1'b0, 32'd0, 1'b0, 32'd0, 1'b1));
    step(1'b1, usa, usb, 1'b1, 1'b0, 1'b0, mk(1'b0, 32'd0, 1'b0, 32'd0, 1'b1));
    step(1'b1, usa, usb, 1'b1, 1'b0, 1'b1, mk(1'b1, usa, 1'b1, usb, 1'b0));
    step(1'b1, bqa, bqb, 1'b1, 1'b0, 1'b0, mk(1'b1, bqa, 1'b0, 32'd0, 1'b0));
    step(1'b1, bqa, bqb, 1'b1, 1'b1, 1'b0, mk(1'b0, 32'd0, 1'b0, 32'd0, 1'b0));
    step(1'b0, 32'd0, 32'd0, 1'b1, 1'b0, 1'b0, mk(1'b0, 32'd0, 1'b0, 32'd0, 1'b0));
    step(1'b1, ina, inb, 1'b1, 1'b0, 1'b1, mk(1'b1, ina, 1'b1, inb, 1'b0));
    step(1'b1, wwa, wwb, 1'b1, 1'b0, 1'b0, mk(1'b1, wwa, 1'b0, 32'd0, 1'b0));
    step(1'b1, wwa, wwb, 1'b1, 1'b0, 1'b1, mk(1'b1, wwb, 1'b0, 32'd0, 1'b0));
    step(1'b1, lla, llb, 1'b1, 1'b0, 1'b0, mk(1'b1, lla, 1'b0, 32'd0, 1'b0));
    step(1'b1, lla, llb, 1'b1, 1'b0, 1'b1, mk(1'b1, llb, 1'b0, 32'd0, 1'b0));
    for (int i = 0; i < 3; i++)
      step(1'b1, sta, stb, 1'b0, 1'b0, 1'b0, mk(1'b1, llb, 1'b0, 32'd0, 1'b0));
    step(1'b1, sta, stb, 1'b1, 1'b0, 1'b1, mk(1'b1, sta, 1'b1, stb, 1'b0));
    step(1'b1, lda, ldb, 1'b1, 1'b0, 1'b1, mk(1'b1, lda, 1'b1, ldb, 1'b0));
    step(1'b1, usa, usb, 1'b1, 1'b0, 1'b0, mk(1'b0, 32'd0, 1'b0, 32'd0, 1'b1));

    @(negedge clk);
    pair_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check_eq("midrst_valid_a", {63'd0, issue_valid_a}, 64'd0);
    check_eq("midrst_valid_b", {63'd0, issue_valid_b}, 64'd0);
    check_eq("midrst_trigger", {63'd0, trigger}, 64'd0);
    check_eq("midrst_instr_a", {32'd0, issue_instr_a}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b1, usa, usb, 1'b1, 1'b0, 1'b1, mk(1'b1, usa, 1'b1, usb, 1'b0));
    step(1'b0, 32'd0, 32'd0, 1'b1, 1'b0, 1'b0, mk(1'b0, 32'd0, 1'b0, 32'd0, 1'b0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
